// File: rtl/rgb_pkg.sv
// Shared constants for the WS2812b capture/transmit paths: status bit positions,
// 96 MHz pulse timing defaults and the transmit FSM state type.
package rgb_pkg;

   localparam int unsigned BNUM_VALID          = 31;
   localparam int unsigned BNUM_STREAM_RESET   = 30;
   localparam int unsigned BNUM_FIRST_DATA_BIT = 23;
   localparam int unsigned BNUM_LAST_DATA_BIT  = 0;

   localparam int unsigned T0H_CYCLES_DEF  = 38;
   localparam int unsigned T1H_CYCLES_DEF  = 77;
   localparam int unsigned TBIT_CYCLES_DEF = 120;
   localparam int unsigned TRST_CYCLES_DEF = 4800;

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow,
      StRstLow
   } tx_state_e;

endpackage

// File: rtl/rgb_pulse_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a load of
// N-1 on state entry gives a phase lasting exactly N cycles.
module rgb_pulse_timer #(
   parameter int unsigned Width = 13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [Width-1:0] load_val,
   output logic             done
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/rgb_wrd2sout.sv
// Pops RGB/status words from a show-ahead FIFO and drives a WS2812b serial line.
// Optional sticky underrun flag is built only when UNDERRUN_DET_EN is defined.
module rgb_wrd2sout
   import rgb_pkg::*;
#(
   parameter int unsigned T0H_CYCLES  = T0H_CYCLES_DEF,
   parameter int unsigned T1H_CYCLES  = T1H_CYCLES_DEF,
   parameter int unsigned TBIT_CYCLES = TBIT_CYCLES_DEF,
   parameter int unsigned TRST_CYCLES = TRST_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_word,
   input  logic        in_rd_fifo_empty,
   output logic        out_rd_fifo_strobe,
   output logic        out_sout,
   output logic        out_busy,
   output logic        out_underrun
);

   localparam int unsigned CntW = $clog2(TRST_CYCLES);
   localparam int unsigned NData = BNUM_FIRST_DATA_BIT - BNUM_LAST_DATA_BIT + 1;

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t HiT0  = cnt_t'(T0H_CYCLES - 1);
   localparam cnt_t HiT1  = cnt_t'(T1H_CYCLES - 1);
   localparam cnt_t LowT0 = cnt_t'(TBIT_CYCLES - T0H_CYCLES - 1);
   localparam cnt_t LowT1 = cnt_t'(TBIT_CYCLES - T1H_CYCLES - 1);
   localparam cnt_t RstV  = cnt_t'(TRST_CYCLES - 1);

   tx_state_e        state_q, state_d;
   logic [NData-1:0] shift_q, shift_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic             take;
   logic             pop;
   logic             load;
   cnt_t             load_val;
   logic             done;

   // Status bits 29..24 carry nothing for the transmitter.
   logic unused_bits;
   assign unused_bits = ^in_word[29:24];

   rgb_pulse_timer #(
      .Width (CntW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      take      = 1'b0;
      pop       = 1'b0;
      load      = 1'b0;
      load_val  = '0;

      unique case (state_q)
         StIdle: begin
            take = !in_rd_fifo_empty;
         end
         StHigh: begin
            if (done) begin
               state_d  = StLow;
               load     = 1'b1;
               load_val = shift_q[NData-1] ? LowT1 : LowT0;
            end
         end
         StLow: begin
            if (done) begin
               if (bit_idx_q != 5'd0) begin
                  bit_idx_d = bit_idx_q - 5'd1;
                  shift_d   = {shift_q[NData-2:0], 1'b0};
                  state_d   = StHigh;
                  load      = 1'b1;
                  load_val  = shift_q[NData-2] ? HiT1 : HiT0;
               end else if (!in_rd_fifo_empty) begin
                  // Pop in the last LOW cycle so the next word follows with no gap.
                  take = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StRstLow: begin
            if (done) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (take) begin
         pop       = 1'b1;
         shift_d   = in_word[BNUM_FIRST_DATA_BIT:BNUM_LAST_DATA_BIT];
         bit_idx_d = 5'(BNUM_FIRST_DATA_BIT);
         if (!in_word[BNUM_VALID]) begin
            state_d = StIdle;
         end else if (in_word[BNUM_STREAM_RESET]) begin
            state_d  = StRstLow;
            load     = 1'b1;
            load_val = RstV;
         end else begin
            state_d  = StHigh;
            load     = 1'b1;
            load_val = in_word[BNUM_FIRST_DATA_BIT] ? HiT1 : HiT0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shift_q   <= '0;
         bit_idx_q <= 5'(BNUM_FIRST_DATA_BIT);
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   // Gate with rst so a non-empty FIFO is never popped while held in reset.
   assign out_rd_fifo_strobe = pop & ~rst;
   assign out_sout           = (state_q == StHigh);
   assign out_busy           = (state_q != StIdle);

`ifdef UNDERRUN_DET_EN
   logic underrun_q;
   logic underrun_evt;

   assign underrun_evt = (state_q == StLow) && done && (bit_idx_q == 5'd0) && in_rd_fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underrun_q <= 1'b0;
      end else if (underrun_evt) begin
         underrun_q <= 1'b1;
      end
   end

   assign out_underrun = underrun_q;
`else
   assign out_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_wrd2sout.sv
// Bench for rgb_wrd2sout: directed table, randomized word streams and corner sequences,
// all compared cycle by cycle against a word-level waveform model.
module tb_rgb_wrd2sout;

   localparam int T0H  = 38;
   localparam int T1H  = 77;
   localparam int TBIT = 120;
   localparam int TRST = 4800;

`ifdef UNDERRUN_DET_EN
   localparam bit UndEn = 1'b1;
`else
   localparam bit UndEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_word = '0;
   logic        in_rd_fifo_empty = 1'b1;
   logic        out_rd_fifo_strobe;
   logic        out_sout;
   logic        out_busy;
   logic        out_underrun;

   rgb_wrd2sout dut (
      .clk                (clk),
      .rst                (rst),
      .in_word            (in_word),
      .in_rd_fifo_empty   (in_rd_fifo_empty),
      .out_rd_fifo_strobe (out_rd_fifo_strobe),
      .out_sout           (out_sout),
      .out_busy           (out_busy),
      .out_underrun       (out_underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] fifo_q[$];
   bit exp_sout[$], exp_busy[$], exp_strb[$], exp_und[$];
   bit act_sout[$], act_busy[$], act_strb[$], act_und[$];

   typedef struct packed {
      logic [3:0][31:0] words;
      logic [2:0]       n;
      logic [5:0]       pulses;
      logic [2:0]       strobes;
      logic [6:0]       first_hi;
      logic             und;
   } vec_t;

   vec_t tbl[5];

   function automatic vec_t mk(logic [31:0] w0, logic [31:0] w1, int n, int pulses,
                               int strobes, int first_hi, bit und);
      vec_t v;
      v.words    = '0;
      v.words[0] = w0;
      v.words[1] = w1;
      v.n        = 3'(n);
      v.pulses   = 6'(pulses);
      v.strobes  = 3'(strobes);
      v.first_hi = 7'(first_hi);
      v.und      = und;
      return v;
   endfunction

   task automatic fifo_drive();
      in_rd_fifo_empty = (fifo_q.size() == 0);
      in_word          = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
   endtask

   function automatic void push_cyc(bit s, bit b, bit st, bit u);
      exp_sout.push_back(s);
      exp_busy.push_back(b);
      exp_strb.push_back(st);
      exp_und.push_back(u);
   endfunction

   // Expected per-cycle waveform for a FIFO preloaded with w, starting from IDLE.
   task automatic build_model(input logic [31:0] w[$]);
      bit und = 1'b0;
      bit overlapped = 1'b0;
      exp_sout = {};
      exp_busy = {};
      exp_strb = {};
      exp_und  = {};
      for (int i = 0; i < w.size(); i++) begin
         bit more = (i < w.size() - 1);
         if (!overlapped) push_cyc(1'b0, 1'b0, 1'b1, und);
         overlapped = 1'b0;
         if (!w[i][31]) continue;
         if (w[i][30]) begin
            repeat (TRST) push_cyc(1'b0, 1'b1, 1'b0, und);
            continue;
         end
         for (int b = 23; b >= 0; b--) begin
            int hi = w[i][b] ? T1H : T0H;
            repeat (hi) push_cyc(1'b1, 1'b1, 1'b0, und);
            repeat (TBIT - hi - 1) push_cyc(1'b0, 1'b1, 1'b0, und);
            if (b == 0 && more) begin
               push_cyc(1'b0, 1'b1, 1'b1, und);
               overlapped = 1'b1;
            end else begin
               push_cyc(1'b0, 1'b1, 1'b0, und);
            end
            if (b == 0 && !more) und = UndEn;
         end
      end
      repeat (20) push_cyc(1'b0, 1'b0, 1'b0, und);
   endtask

   task automatic check_trace(input string nm, input bit act[$], input bit exp[$]);
      int bad = -1;
      for (int k = 0; k < exp.size(); k++) begin
         if (k >= act.size() || act[k] != exp[k]) begin
            bad = k;
            break;
         end
      end
      n_checks++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got %0b expected %0b", nm, bad,
                  (bad < act.size()) ? act[bad] : 1'b0, exp[bad]);
      end
   endtask

   task automatic check_val(input string nm, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   // Reset the DUT with the FIFO preloaded, then record and compare every cycle.
   task automatic run_trace(input logic [31:0] w[$], input string tag);
      bit s;
      build_model(w);
      @(posedge clk);
      #2 rst = 1'b1;
      fifo_q = w;
      fifo_drive();
      @(negedge clk);
      check_val({tag, " reset outputs"},
                int'({out_sout, out_busy, out_rd_fifo_strobe, out_underrun}), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      act_sout = {};
      act_busy = {};
      act_strb = {};
      act_und  = {};
      for (int k = 0; k < exp_sout.size(); k++) begin
         act_sout.push_back(out_sout);
         act_busy.push_back(out_busy);
         act_strb.push_back(out_rd_fifo_strobe);
         act_und.push_back(out_underrun);
         s = out_rd_fifo_strobe;
         @(posedge clk);
         #1;
         if (s && fifo_q.size() != 0) void'(fifo_q.pop_front());
         fifo_drive();
         @(negedge clk);
      end
      check_trace({tag, " sout"}, act_sout, exp_sout);
      check_trace({tag, " busy"}, act_busy, exp_busy);
      check_trace({tag, " strobe"}, act_strb, exp_strb);
      check_trace({tag, " underrun"}, act_und, exp_und);
   endtask

   function automatic int count_rises();
      int c = 0;
      for (int k = 1; k < act_sout.size(); k++) if (act_sout[k] && !act_sout[k-1]) c++;
      return c;
   endfunction

   function automatic int count_strobes();
      int c = 0;
      foreach (act_strb[k]) if (act_strb[k]) c++;
      return c;
   endfunction

   function automatic int first_high_width();
      int c = 0;
      bit seen = 1'b0;
      foreach (act_sout[k]) begin
         if (act_sout[k]) begin
            c++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
      end
      return c;
   endfunction

   initial begin
      logic [31:0] wq[$];
      bit had_rst;
      bit all_quiet;

      tbl[0] = mk(32'h80AA5500, 32'h0, 1, 24, 1, 77, 1'b1);
      tbl[1] = mk(32'h80FFFFFF, 32'h80000000, 2, 48, 2, 77, 1'b1);
      tbl[2] = mk(32'hC0123456, 32'h0, 1, 0, 1, 0, 1'b0);
      tbl[3] = mk(32'h00FFFFFF, 32'h80800000, 2, 24, 2, 77, 1'b1);
      tbl[4] = mk(32'hC0000000, 32'hC0000000, 2, 0, 2, 0, 1'b0);

      fifo_drive();
      repeat (3) @(posedge clk);

      for (int i = 0; i < 5; i++) begin
         wq = {};
         for (int j = 0; j < int'(tbl[i].n); j++) wq.push_back(tbl[i].words[j]);
         run_trace(wq, $sformatf("vec%0d", i));
         check_val($sformatf("vec%0d pulses", i), count_rises(), int'(tbl[i].pulses));
         check_val($sformatf("vec%0d strobes", i), count_strobes(), int'(tbl[i].strobes));
         check_val($sformatf("vec%0d first_high", i), first_high_width(),
                   int'(tbl[i].first_hi));
         check_val($sformatf("vec%0d final_underrun", i), int'(act_und[act_und.size()-1]),
                   int'(tbl[i].und & UndEn));
      end

      for (int r = 0; r < 3; r++) begin
         wq = {};
         had_rst = 1'b0;
         for (int j = 0; j < 3; j++) begin
            int t = $urandom_range(0, 9);
            logic [31:0] rw = $urandom();
            if (t == 0 && !had_rst) begin
               rw[31:30] = 2'b11;
               had_rst = 1'b1;
            end else if (t <= 2) begin
               rw[31] = 1'b0;
            end else begin
               rw[31:30] = 2'b10;
            end
            wq.push_back(rw);
         end
         run_trace(wq, $sformatf("rand%0d", r));
      end

      // Reset 50 cycles into the HIGH of a "1" bit must drop the line at once.
      @(posedge clk);
      #2 rst = 1'b1;
      fifo_q = {32'h80800000};
      fifo_drive();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      void'(fifo_q.pop_front());
      fifo_drive();
      repeat (50) @(posedge clk);
      #3;
      check_val("midbit sout before rst", int'(out_sout), 1);
      fifo_q = {32'h80000001};
      fifo_drive();
      rst = 1'b1;
      #1;
      check_val("midbit async outputs", int'({out_sout, out_busy, out_rd_fifo_strobe,
                                             out_underrun}), 0);
      wq = {32'h80000001};
      run_trace(wq, "restart");
      check_val("restart first_high", first_high_width(), T0H);

      // Idle with an empty FIFO: nothing may move.
      @(posedge clk);
      #2 rst = 1'b1;
      fifo_q = {};
      fifo_drive();
      @(posedge clk);
      #2 rst = 1'b0;
      all_quiet = 1'b1;
      for (int k = 0; k < 10000; k++) begin
         @(negedge clk);
         if (out_rd_fifo_strobe || out_sout || out_busy) all_quiet = 1'b0;
      end
      check_val("empty idle quiet", int'(all_quiet), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rgb_wrd2sout.md
Name: rgb_wrd2sout

Overview:
- Transmit-side counterpart of the serial-bit-to-word capture path. Pops 32-bit Red/Green/Blue/Status words from a show-ahead FIFO and drives a WS2812b-protocol serial line.
- Sits between the output FIFO and the LED-string data pin.
- Runs on the 96 MHz PLL clock; all pulse timing is counted in clk cycles.

Parameters:
- T0H_CYCLES, 38, high time of a "0" bit (0.40 us at 96 MHz)
- T1H_CYCLES, 77, high time of a "1" bit (0.80 us)
- TBIT_CYCLES, 120, total bit period (1.25 us); must be > T1H_CYCLES
- TRST_CYCLES, 4800, low time for a stream reset (50 us)

Ports:
- clk  in  1  clock, expected to be 96 MHz
- rst  in  1  asynchronous, active-high reset
- in_word  in  32  FIFO head word; valid whenever in_rd_fifo_empty==0. bit31 valid, bit30 stream_reset, bits23..0 G-R-B data, MSB first
- in_rd_fifo_empty  in  1  1 = no word available
- out_rd_fifo_strobe  out  1  one-clock pop of the FIFO head
- out_sout  out  1  serial data line to LEDs
- out_busy  out  1  1 while a bit or stream reset is being driven
- out_underrun  out  1  sticky; see Optional Feature

Behaviour:
- Reset (async, rst=1): state IDLE; out_sout=0, out_rd_fifo_strobe=0, out_busy=0, out_underrun=0; bit counter=23; cycle counter=0; shift register=0.
- States: IDLE, HIGH, LOW, RSTLOW.
- IDLE, empty=0: pop the word (strobe=1 for exactly 1 cycle) and latch in_word in the same cycle. Then dispatch on the latched word:
  - valid=0: discard; stay IDLE; next word may be popped on the following cycle.
  - stream_reset=1: go to RSTLOW; data bits are ignored.
  - otherwise: go to HIGH with bit index 23.
- HIGH: out_sout=1 for T1H_CYCLES if the current bit is 1, else T0H_CYCLES; then go to LOW.
- LOW: out_sout=0 until the total bit period equals TBIT_CYCLES exactly.
  - If bit index > 0: decrement the index, go to HIGH.
  - If index = 0 and empty=0: pop and dispatch in the last LOW cycle, so the next bit's HIGH starts with zero gap.
  - If index = 0 and empty=1: go to IDLE and record an underrun.
- RSTLOW: out_sout=0 for TRST_CYCLES, then IDLE.
- Latency: the rising edge of out_sout occurs on the clock after the pop. out_busy=1 in HIGH, LOW and RSTLOW.
- Cycle counter: $clog2(TRST_CYCLES) bits (13 for the defaults); cleared on every state entry.
- Strobe never asserts while empty=1.
- rst mid-bit: out_sout drops to 0 immediately (asynchronously). The partially sent word is lost and is not re-popped.
- Back-to-back stream-reset words are each honoured in full (2 x TRST_CYCLES).

Optional Feature:
- UNDERRUN_DET_EN defined: out_underrun sets to 1 when a data word (valid=1, stream_reset=0) completes with the FIFO empty. It stays set until rst. An underrun does not alter waveform timing.
- Not defined: out_underrun is constant 0 and no detection logic is synthesized.

Decomposition:
- Shared package (rgb_pkg):
  - status bit positions BNUM_VALID=31, BNUM_STREAM_RESET=30
  - BNUM_FIRST_DATA_BIT=23, BNUM_LAST_DATA_BIT=0
  - 96 MHz timing defaults
  - state enum for IDLE/HIGH/LOW/RSTLOW
- These bit positions are also used by the capture block.
- One natural sub-module, rgb_pulse_timer: a loadable down-counter with a done flag, instantiated once and reused by HIGH, LOW and RSTLOW.

Test Plan:
- Single word 0x80AA5500 then FIFO empty:
  - 24 pulses, MSB first, high widths 77/38 alternating for 0xAA, then 0x55 pattern, then eight 38s.
  - Every period is exactly 120 cycles; one strobe; with UNDERRUN_DET_EN, out_underrun=1 after the last bit.
- Two words 0x80FFFFFF, 0x80000000 preloaded:
  - 48 contiguous periods, no extra cycles between words (rising edges every 120 cycles).
  - Second strobe lands in the last LOW cycle of bit 0; out_underrun=0 until after the second word.
- Word 0xC0123456:
  - out_sout=0 and out_busy=1 for exactly 4800 cycles; no data pulses; then IDLE.
- Word 0x00FFFFFF (valid=0) followed by 0x80800000:
  - first is popped and discarded with no waveform.
  - second yields first pulse 77 cycles high, then 23 x 38.
- rst asserted 50 cycles into a "1" bit's HIGH:
  - out_sout=0 in the same cycle (async); all outputs return to reset values.
  - After release with the FIFO holding 0x80000001, transmission restarts cleanly at bit 23.
- FIFO held empty for 10000 cycles after reset:
  - no strobe, out_sout=0, out_busy=0 throughout.
